// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman result path: score width,
// tracker FSM states and a constant-foldable clog2.
package sw_pkg;

  localparam int SCORE_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sw_group_argmax.sv
// Combinational argmax over N unsigned scores; the strict compare keeps the
// lowest index when several inputs share the maximum.
module sw_group_argmax #(
  parameter int N     = 8,
  parameter int W     = 10,
  parameter int IDX_W = 3
) (
  input  logic [N*W-1:0]   vals,
  output logic [W-1:0]     max_val,
  output logic [IDX_W-1:0] max_idx
);

  always_comb begin
    max_val = vals[W-1:0];
    max_idx = '0;
    for (int i = 1; i < N; i++) begin
      if (vals[i*W +: W] > max_val) begin
        max_val = vals[i*W +: W];
        max_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sw_max_score_tracker.sv
// Running-max tracker on the systolic score bus: registered per-group argmax,
// group reduction into a running max, one result word per alignment.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start_in; score beats ignored
// ST_TRACK | beats tagged with the beat counter enter the pipeline
// ST_DRAIN | two cycles for the last beat to reach the running max
// ST_HOLD  | result word valid and stable until result_rdy_in
module sw_max_score_tracker
  import sw_pkg::*;
#(
  parameter int NUM_PES = 64,
  parameter int WIDTH   = SCORE_W,
  parameter int GROUP   = 8,
  parameter int COL_W   = 32,
  localparam int PE_W   = (NUM_PES > 1) ? clog2(NUM_PES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_in,
  input  logic [NUM_PES*WIDTH-1:0] V_in,
  input  logic                     V_valid_in,
  input  logic                     last_in,
  output logic [WIDTH-1:0]         result_score_out,
  output logic [PE_W-1:0]          result_pe_out,
  output logic [COL_W-1:0]         result_col_out,
  output logic                     result_valid_out,
  input  logic                     result_rdy_in,
  output logic                     busy_out
);

  localparam int NG   = NUM_PES / GROUP;
  localparam int LI_W = (GROUP > 1) ? clog2(GROUP) : 1;
  localparam int GI_W = (NG > 1) ? clog2(NG) : 1;

  state_t            state;
  logic              drain_cnt;
  logic [COL_W-1:0]  col_cnt;

  logic [WIDTH-1:0]  grp_max [NG];
  logic [LI_W-1:0]   grp_idx [NG];

  logic              s1_valid;
  logic [COL_W-1:0]  s1_col;
  logic [WIDTH-1:0]  s1_max [NG];
  logic [LI_W-1:0]   s1_idx [NG];
  logic [NG*WIDTH-1:0] s1_max_flat;

  logic [WIDTH-1:0]  s2_max;
  logic [GI_W-1:0]   s2_grp;
  logic [PE_W-1:0]   s2_pe;

  logic [WIDTH-1:0]  run_score;
  logic [PE_W-1:0]   run_pe;
  logic [COL_W-1:0]  run_col;

  logic beat_take;
  logic start_take;

  assign beat_take  = V_valid_in && (state == ST_TRACK);
  assign start_take = start_in && (state == ST_IDLE);

  for (genvar g = 0; g < NG; g++) begin : g_stage1
    sw_group_argmax #(.N(GROUP), .W(WIDTH), .IDX_W(LI_W)) u_grp (
      .vals    (V_in[g*GROUP*WIDTH +: GROUP*WIDTH]),
      .max_val (grp_max[g]),
      .max_idx (grp_idx[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_col   <= '0;
      s1_max   <= '{default: '0};
      s1_idx   <= '{default: '0};
      col_cnt  <= '0;
    end else begin
      s1_valid <= beat_take;
      if (beat_take) begin
        s1_col <= col_cnt;
        s1_max <= grp_max;
        s1_idx <= grp_idx;
        if (col_cnt != '1) col_cnt <= col_cnt + COL_W'(1);
      end else if (start_take) begin
        col_cnt <= '0;
      end
    end
  end

  always_comb begin
    s1_max_flat = '0;
    for (int g = 0; g < NG; g++) s1_max_flat[g*WIDTH +: WIDTH] = s1_max[g];
  end

  sw_group_argmax #(.N(NG), .W(WIDTH), .IDX_W(GI_W)) u_stage2 (
    .vals    (s1_max_flat),
    .max_val (s2_max),
    .max_idx (s2_grp)
  );

  assign s2_pe = PE_W'(s2_grp) * PE_W'(GROUP) + PE_W'(s1_idx[s2_grp]);

  // Strict compare: an equal score on a later beat never displaces the earlier one.
  always_ff @(posedge clk) begin
    if (!rst || start_take) begin
      run_score <= '0;
      run_pe    <= '0;
      run_col   <= '0;
    end else if (s1_valid && (s2_max > run_score)) begin
      run_score <= s2_max;
      run_pe    <= s2_pe;
      run_col   <= s1_col;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= ST_IDLE;
      drain_cnt        <= 1'b0;
      busy_out         <= 1'b0;
      result_valid_out <= 1'b0;
      result_score_out <= '0;
      result_pe_out    <= '0;
      result_col_out   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_in) begin
            state    <= ST_TRACK;
            busy_out <= 1'b1;
          end
        end
        ST_TRACK: begin
          if (V_valid_in && last_in) begin
            state     <= ST_DRAIN;
            drain_cnt <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 1'b0) begin
            state            <= ST_HOLD;
            result_valid_out <= 1'b1;
            result_score_out <= run_score;
            result_pe_out    <= run_pe;
            result_col_out   <= run_col;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (result_rdy_in) begin
            state            <= ST_IDLE;
            result_valid_out <= 1'b0;
            busy_out         <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_max_score_tracker.sv
// Directed bench for sw_max_score_tracker with hand-computed expectations and
// a small reference max model for the long random stream.
module tb_sw_max_score_tracker;

  localparam int NP = 64;
  localparam int W  = 10;
  localparam int CW = 32;
  localparam int PW = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start_in = 1'b0;
  logic [NP*W-1:0]  V_in = '0;
  logic             V_valid_in = 1'b0;
  logic             last_in = 1'b0;
  logic             result_rdy_in = 1'b0;
  logic [W-1:0]     result_score_out;
  logic [PW-1:0]    result_pe_out;
  logic [CW-1:0]    result_col_out;
  logic             result_valid_out;
  logic             busy_out;

  int checks = 0;
  int errors = 0;

  logic [NP*W-1:0] vec;

  sw_max_score_tracker dut (
    .clk              (clk),
    .rst              (rst),
    .start_in         (start_in),
    .V_in             (V_in),
    .V_valid_in       (V_valid_in),
    .last_in          (last_in),
    .result_score_out (result_score_out),
    .result_pe_out    (result_pe_out),
    .result_col_out   (result_col_out),
    .result_valid_out (result_valid_out),
    .result_rdy_in    (result_rdy_in),
    .busy_out         (busy_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [NP*W-1:0] v, input logic last);
    V_in       = v;
    V_valid_in = 1'b1;
    last_in    = last;
    tick();
    V_valid_in = 1'b0;
    last_in    = 1'b0;
    V_in       = '0;
  endtask

  task automatic start_run();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int n;
    n = 0;
    while (!result_valid_out && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 64'(result_valid_out), 64'd1);
  endtask

  task automatic expect_result(input string tag, input int score, input int pe, input int col);
    wait_result(tag);
    chk({tag, "_score"}, 64'(result_score_out), 64'(score));
    chk({tag, "_pe"},    64'(result_pe_out),    64'(pe));
    chk({tag, "_col"},   64'(result_col_out),   64'(col));
    result_rdy_in = 1'b1;
    tick();
    result_rdy_in = 1'b0;
    chk({tag, "_valid_drop"}, 64'(result_valid_out), 64'd0);
  endtask

  initial begin
    int  m_score, m_pe, m_col, s;
    bit  busy_bad, hold_bad;

    // reset state
    rst = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'(result_valid_out), 64'd0);
    chk("rst_busy",  64'(busy_out),         64'd0);
    chk("rst_score", 64'(result_score_out), 64'd0);
    chk("rst_pe",    64'(result_pe_out),    64'd0);
    chk("rst_col",   64'(result_col_out),   64'd0);
    rst = 1'b1;
    tick();

    // basic: PE17=45 on beat 1, last on beat 2, valid exactly 3 cycles later
    start_run();
    chk("t1_busy", 64'(busy_out), 64'd1);
    beat('0, 1'b0);
    vec = '0;
    vec[17*W +: W] = 10'd45;
    beat(vec, 1'b0);
    beat('0, 1'b1);
    tick();
    chk("t1_valid_n2", 64'(result_valid_out), 64'd0);
    tick();
    chk("t1_valid_n3", 64'(result_valid_out), 64'd1);
    chk("t1_score", 64'(result_score_out), 64'd45);
    chk("t1_pe",    64'(result_pe_out),    64'd17);
    chk("t1_col",   64'(result_col_out),   64'd1);
    result_rdy_in = 1'b1;
    tick();
    result_rdy_in = 1'b0;
    chk("t1_valid_drop", 64'(result_valid_out), 64'd0);
    chk("t1_busy_idle",  64'(busy_out),         64'd0);
    chk("t1_score_hold", 64'(result_score_out), 64'd45);

    // ties, plus a start_in pulse during TRACK that must be ignored
    start_run();
    vec = '0;
    vec[5*W +: W]  = 10'd100;
    vec[40*W +: W] = 10'd100;
    beat(vec, 1'b0);
    beat('0, 1'b0);
    start_in = 1'b1;
    beat('0, 1'b0);
    start_in = 1'b0;
    vec = '0;
    vec[2*W +: W] = 10'd100;
    beat(vec, 1'b1);
    expect_result("tie", 100, 5, 0);

    // full-rate 1000-beat stream against the reference model
    start_run();
    m_score = 0; m_pe = 0; m_col = 0;
    busy_bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      vec = '0;
      for (int p = 0; p < NP; p++) begin
        s = int'($urandom_range(0, 23 + i));
        vec[p*W +: W] = W'(s);
        if (s > m_score) begin
          m_score = s; m_pe = p; m_col = i;
        end
      end
      beat(vec, i == 999);
      if (!busy_out) busy_bad = 1'b1;
    end
    wait_result("stream");
    chk("stream_busy", 64'(busy_bad), 64'd0);
    hold_bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      start_in = (c == 3);
      tick();
      start_in = 1'b0;
      if (result_valid_out !== 1'b1 || busy_out !== 1'b1 ||
          result_score_out !== W'(m_score) || result_pe_out !== PW'(m_pe) ||
          result_col_out !== CW'(m_col))
        hold_bad = 1'b1;
    end
    chk("stream_hold_stable", 64'(hold_bad), 64'd0);
    chk("stream_score", 64'(result_score_out), 64'(m_score));
    chk("stream_pe",    64'(result_pe_out),    64'(m_pe));
    chk("stream_col",   64'(result_col_out),   64'(m_col));
    result_rdy_in = 1'b1;
    tick();
    result_rdy_in = 1'b0;
    chk("stream_valid_drop", 64'(result_valid_out), 64'd0);
    tick();
    chk("hold_start_ignored", 64'(busy_out), 64'd0);

    // reset mid-TRACK after 4 beats
    start_run();
    vec = '0;
    vec[10*W +: W] = 10'd500;
    beat('0, 1'b0);
    beat(vec, 1'b0);
    beat(vec, 1'b0);
    beat('0, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_valid", 64'(result_valid_out), 64'd0);
    chk("mid_rst_busy",  64'(busy_out),         64'd0);
    chk("mid_rst_score", 64'(result_score_out), 64'd0);
    chk("mid_rst_pe",    64'(result_pe_out),    64'd0);
    chk("mid_rst_col",   64'(result_col_out),   64'd0);
    tick();
    start_run();
    vec = '0;
    vec[3*W +: W] = 10'd7;
    beat(vec, 1'b0);
    beat('0, 1'b1);
    expect_result("post_rst", 7, 3, 0);

    // beats in IDLE are ignored
    V_in       = '1;
    V_valid_in = 1'b1;
    last_in    = 1'b1;
    tick();
    tick();
    tick();
    V_valid_in = 1'b0;
    last_in    = 1'b0;
    V_in       = '0;
    chk("idle_beats_busy", 64'(busy_out), 64'd0);
    start_run();
    vec = '0;
    vec[8*W +: W] = 10'd9;
    beat(vec, 1'b0);
    beat('0, 1'b1);
    expect_result("idle_beats", 9, 8, 0);

    // single-beat alignment at the top PE and full-scale score
    start_run();
    vec = '0;
    vec[63*W +: W] = 10'd1023;
    beat(vec, 1'b1);
    expect_result("single", 1023, 63, 0);

    // all-zero alignment
    start_run();
    beat('0, 1'b0);
    beat('0, 1'b1);
    expect_result("zeros", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
